// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// Capture stage behind the 16-bit adder. Each accepted adder result (sum F plus
// flags C, P, O, Z, S) is written into a small first-word-fall-through FIFO
// with valid/ready handshakes on both sides. Optional status logic tracks
// sticky carry/overflow, counts overflowing results and flags results whose
// Z/S flags disagree with the sum.
//
// Build option:
//   ALU_FIFO_STATUS_EN  defined   -> sticky / ovf_cnt / err logic is built
//                       undefined -> those outputs are tied to 0 and
//                                    sticky_clr is ignored
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of the overflow event counter
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake
//   in_f              adder sum
//   in_c/p/o/z/s      adder flags
//   out_valid/out_ready downstream handshake
//   out_f, out_flags  head entry; flags packed {S,Z,O,P,C}
//   count             current occupancy
//   sticky            {O,C} sticky status
//   sticky_clr        clears sticky, ovf_cnt and err
//   ovf_cnt           accepted entries with O=1 (saturating)
//   err               sticky flag-consistency error
// -----------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_f,
  input  logic                       in_c,
  input  logic                       in_p,
  input  logic                       in_o,
  input  logic                       in_z,
  input  logic                       in_s,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_f,
  output logic [4:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 sticky,
  input  logic                       sticky_clr,
  output logic [CNT_W-1:0]           ovf_cnt,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]  flags;  // {S,Z,O,P,C}
    logic [15:0] f;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          push, pop;

  // Handshakes depend only on registered occupancy, so out_ready never
  // reaches in_ready combinationally. A full FIFO refuses a push even when a
  // pop happens in the same cycle.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // First-word fall-through: the head location is always visible.
  assign out_f     = mem_q[rd_ptr_q].f;
  assign out_flags = mem_q[rd_ptr_q].flags;
  assign count     = count_q;

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the data array has no reset; out_valid gates its contents, and
  // leaving it unreset lets it map onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{flags: {in_s, in_z, in_o, in_p, in_c}, f: in_f};
    end
  end

`ifdef ALU_FIFO_STATUS_EN
  logic [1:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] ovf_q,    ovf_d;
  logic             err_q,    err_d;
  logic             flag_bad;

  // P is not checked: parity of the sum is not cheaply re-derivable here
  // in a way the adder guarantees, so only Z and S are cross-checked.
  assign flag_bad = (in_z != (in_f == 16'h0000)) || (in_s != in_f[15]);

  // Clear is applied first and a push then sets on top of it, so a push in
  // the clearing cycle wins.
  always_comb begin
    sticky_d = sticky_clr ? 2'b00 : sticky_q;
    ovf_d    = sticky_clr ? '0    : ovf_q;
    err_d    = sticky_clr ? 1'b0  : err_q;
    if (push) begin
      if (in_o) sticky_d[1] = 1'b1;
      if (in_c) sticky_d[0] = 1'b1;
      if (in_o && (ovf_d != {CNT_W{1'b1}})) ovf_d = ovf_d + 1'b1;
      if (flag_bad) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 2'b00;
      ovf_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign sticky  = sticky_q;
  assign ovf_cnt = ovf_q;
  assign err     = err_q;
`else
  // Status logic not built; sticky_clr has no effect.
  logic status_unused;
  assign status_unused = sticky_clr;
  assign sticky  = 2'b00;
  assign ovf_cnt = '0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_alu_result_fifo
//
// Directed bench for alu_result_fifo (DEPTH=4, CNT_W=8). Inputs change #1
// after a rising edge and outputs are examined at that same point, away from
// the active edge. Status expectations collapse to 0 when the design is built
// without ALU_FIFO_STATUS_EN.
// -----------------------------------------------------------------------------
module tb_alu_result_fifo;

`ifdef ALU_FIFO_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_f;
  logic        in_c, in_p, in_o, in_z, in_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_f;
  logic [4:0]  out_flags;
  logic [2:0]  count;
  logic [1:0]  sticky;
  logic        sticky_clr;
  logic [7:0]  ovf_cnt;
  logic        err;

  int vectors = 0;
  int fails   = 0;

  logic [15:0] exp_q[$];

  alu_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_f       (in_f),
    .in_c       (in_c),
    .in_p       (in_p),
    .in_o       (in_o),
    .in_z       (in_z),
    .in_s       (in_s),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_flags  (out_flags),
    .count      (count),
    .sticky     (sticky),
    .sticky_clr (sticky_clr),
    .ovf_cnt    (ovf_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected status value: zero when the status logic is not built.
  function automatic logic [31:0] st(input logic [31:0] v);
    return STATUS_EN ? v : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags packed {S,Z,O,P,C}
  task automatic drive(input logic v, input logic [15:0] f, input logic [4:0] fl);
    in_valid = v;
    in_f     = f;
    {in_s, in_z, in_o, in_p, in_c} = fl;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; sticky_clr = 1'b0;
    drive(1'b0, 16'h0000, 5'b00000);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_sticky",    32'(sticky),    32'd0);
    check("rst_ovf",       32'(ovf_cnt),   32'd0);
    check("rst_err",       32'(err),       32'd0);

    // 8fff + 8000 = 0fff with C=1, O=1
    drive(1'b1, 16'h0fff, 5'b00101);
    tick();
    drive(1'b0, 16'h0000, 5'b00000);
    check("p1_out_valid", 32'(out_valid), 32'd1);
    check("p1_out_f",     32'(out_f),     32'h0fff);
    check("p1_out_flags", 32'(out_flags), 32'b00101);
    check("p1_sticky",    32'(sticky),    st(32'b11));
    check("p1_ovf",       32'(ovf_cnt),   st(32'd1));
    check("p1_count",     32'(count),     32'd1);
    check("p1_err",       32'(err),       32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("p1_drained", 32'(count), 32'd0);

    // Two entries queued, then popped in order
    drive(1'b1, 16'h0000, 5'b01001);
    tick();
    drive(1'b1, 16'hffff, 5'b10000);
    tick();
    drive(1'b0, 16'h0000, 5'b00000);
    check("p2_count",  32'(count),     32'd2);
    check("p2_f0",     32'(out_f),     32'h0000);
    check("p2_fl0",    32'(out_flags), 32'b01001);
    out_ready = 1'b1;
    tick();
    check("p2_f1",     32'(out_f),     32'hffff);
    check("p2_fl1",    32'(out_flags), 32'b10000);
    check("p2_count1", 32'(count),     32'd1);
    tick();
    out_ready = 1'b0;
    check("p2_empty",  32'(out_valid), 32'd0);
    check("p2_err",    32'(err),       32'd0);

    // Fill to DEPTH, fifth push refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 5'b00000);
      tick();
    end
    check("full_count",    32'(count),    32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 16'h1004, 5'b00000);
    tick();
    check("full_refused",  32'(count),    32'd4);
    check("full_head",     32'(out_f),    32'h1000);

    // Streaming with pointer wrap; a full FIFO refuses the push in its pop
    // cycle, so the first cycle only drains.
    exp_q = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic do_push, do_pop;
      drive(1'b1, 16'h2000 + 16'(k), 5'b00000);
      do_push = (exp_q.size() != 4);
      do_pop  = (exp_q.size() != 0);
      tick();
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(16'h2000 + 16'(k));
      check($sformatf("wrap_count_%0d", k), 32'(count), 32'(exp_q.size()));
      check($sformatf("wrap_head_%0d", k),  32'(out_f), 32'(exp_q[0]));
    end
    drive(1'b0, 16'h0000, 5'b00000);
    while (exp_q.size() != 0) begin
      check("drain_head", 32'(out_f), 32'(exp_q[0]));
      tick();
      void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);

    // Inconsistent Z flag sets err
    drive(1'b1, 16'h0001, 5'b01000);
    tick();
    drive(1'b0, 16'h0000, 5'b00000);
    check("err_set", 32'(err), st(32'd1));

    // Clear alone (entry also popped this cycle)
    sticky_clr = 1'b1; out_ready = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("clr_err",    32'(err),     32'd0);
    check("clr_sticky", 32'(sticky),  32'd0);
    check("clr_ovf",    32'(ovf_cnt), 32'd0);
    check("clr_count",  32'(count),   32'd0);

    // Push with O,C; then clear coinciding with an O push: set wins
    drive(1'b1, 16'h0005, 5'b00101);
    tick();
    check("pre_ovf",    32'(ovf_cnt), st(32'd1));
    drive(1'b1, 16'h0006, 5'b00100);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("clrwin_sticky", 32'(sticky),  st(32'b10));
    check("clrwin_ovf",    32'(ovf_cnt), st(32'd1));

    // Saturation: 259 more O pushes from ovf_cnt=1
    drive(1'b1, 16'h0007, 5'b00100);
    for (int n = 1; n <= 259; n++) begin
      tick();
      if (n == 100) check("sat_mid", 32'(ovf_cnt), st(32'd101));
    end
    drive(1'b0, 16'h0000, 5'b00000);
    check("sat_ovf", 32'(ovf_cnt), st(32'd255));
    tick(); tick();
    out_ready = 1'b0;
    check("sat_drained", 32'(count), 32'd0);

    // Reset with three entries queued (one inconsistent: S=0 with F[15]=1)
    drive(1'b1, 16'h0100, 5'b00000); tick();
    drive(1'b1, 16'h8000, 5'b00000); tick();
    drive(1'b1, 16'h0102, 5'b00000); tick();
    drive(1'b0, 16'h0000, 5'b00000);
    check("q3_count", 32'(count), 32'd3);
    check("q3_err",   32'(err),   st(32'd1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_count",     32'(count),     32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready",  32'(in_ready),  32'd1);
    check("mrst_sticky",    32'(sticky),    32'd0);
    check("mrst_ovf",       32'(ovf_cnt),   32'd0);
    check("mrst_err",       32'(err),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
